// File: rtl/rdata_aligner.sv
// rdata_aligner: fetches B-aligned beats covering [start, endAddr] and repacks
// them into an unaligned little-endian word stream for a sequential reader.
// Optional feature macro: RDATA_BYTE_MASK_EN zeroes bytes of the final word past endAddr.
// AXI_LEN_W normally comes from axi_dma.vh; 8 is used when it is not already defined.
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif

module rdata_aligner #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  run,
    input  logic [ADDR_W-1:0]     endAddr,
    input  logic                  dbus_valid,
    input  logic [ADDR_W-1:0]     dbus_addr,
    output logic [DATA_W-1:0]     dbus_rdata,
    output logic                  dbus_ready,
    output logic                  dma_r_valid,
    output logic [ADDR_W-1:0]     dma_r_addr,
    input  logic [DATA_W-1:0]     dma_r_rdata,
    input  logic                  dma_r_ready,
    output logic [`AXI_LEN_W-1:0] dma_r_len
);
    localparam int unsigned B        = DATA_W / 8;
    localparam int unsigned OFFSET_W = $clog2(B);
    localparam int unsigned CNT_W    = ADDR_W - OFFSET_W + 1;
    localparam int unsigned LEN_W    = `AXI_LEN_W;

`ifdef RDATA_BYTE_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CONFIG, FETCH, TAIL} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   start;
    logic [OFFSET_W-1:0] offset;
    logic [CNT_W-1:0]    beats_rem;
    logic [CNT_W-1:0]    words_form;
    logic [CNT_W-1:0]    words_hand;
    logic                tail_owed;
    logic                primed;
    logic                full;
    logic [DATA_W-1:0]   prev;
    logic [B-1:0]        last_mask;

    logic                beat_fire;
    logic                word_take;
    logic [ADDR_W-1:0]   span;
    logic                backwards;
    logic [CNT_W-1:0]    cfg_beats;
    logic [CNT_W-1:0]    cfg_words;
    logic [B-1:0]        cfg_mask;
    logic [DATA_W-1:0]   beat_word;
    logic [DATA_W-1:0]   tail_word;

    // Maximum burst length encoding for n remaining beats
    function automatic logic [LEN_W-1:0] len_of(input logic [CNT_W-1:0] n);
        if (n == '0) return '0;
        if ((n - CNT_W'(1)) > CNT_W'({LEN_W{1'b1}})) return '1;
        return LEN_W'(n - CNT_W'(1));
    endfunction

    // Zero bytes past endAddr in the final word when masking is built in
    function automatic logic [DATA_W-1:0] finish_word(input logic [DATA_W-1:0] w,
                                                      input logic is_last,
                                                      input logic [B-1:0] m);
        logic [DATA_W-1:0] r;
        r = w;
        for (int j = 0; j < B; j++) begin
            if (MASK_EN && is_last && !m[j]) r[8*j +: 8] = 8'h00;
        end
        return r;
    endfunction

    // Fetch only when a produced word has somewhere to go; hand over only on request
    assign dma_r_valid = (state == FETCH) && (beats_rem != '0) && (!full || dbus_valid);
    assign dbus_ready  = full && dbus_valid;
    assign beat_fire   = dma_r_valid && dma_r_ready;
    assign word_take   = dbus_ready;

    // Region geometry and byte-stream realignment
    always_comb begin
        span      = endAddr - start;
        backwards = start > endAddr;
        cfg_beats = CNT_W'(endAddr[ADDR_W-1:OFFSET_W] - start[ADDR_W-1:OFFSET_W]) + CNT_W'(1);
        cfg_words = CNT_W'(span[ADDR_W-1:OFFSET_W]) + CNT_W'(1);
        if (backwards) begin
            cfg_beats = CNT_W'(1);
            cfg_words = CNT_W'(1);
        end
        for (int j = 0; j < B; j++) begin
            cfg_mask[j] = backwards || (OFFSET_W'(j) <= span[OFFSET_W-1:0]);
        end
        if (offset == '0) beat_word = dma_r_rdata;
        else              beat_word = DATA_W'({dma_r_rdata, prev} >> {offset, 3'b000});
        tail_word = DATA_W'({{DATA_W{1'b0}}, prev} >> {offset, 3'b000});
    end

    // Sequencer, beat counters, shift registers and output holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            start      <= '0;
            offset     <= '0;
            beats_rem  <= '0;
            words_form <= '0;
            words_hand <= '0;
            tail_owed  <= 1'b0;
            primed     <= 1'b0;
            full       <= 1'b0;
            prev       <= '0;
            last_mask  <= '0;
            dbus_rdata <= '0;
            dma_r_addr <= '0;
            dma_r_len  <= '0;
        end else if (clear) begin
            state      <= IDLE;
            start      <= '0;
            offset     <= '0;
            beats_rem  <= '0;
            words_form <= '0;
            words_hand <= '0;
            tail_owed  <= 1'b0;
            primed     <= 1'b0;
            full       <= 1'b0;
            prev       <= '0;
            last_mask  <= '0;
            dbus_rdata <= '0;
            dma_r_addr <= '0;
            dma_r_len  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run && dbus_valid) begin
                        start <= dbus_addr;
                        state <= CONFIG;
                    end
                end
                CONFIG: begin
                    offset     <= start[OFFSET_W-1:0];
                    dma_r_addr <= {start[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    beats_rem  <= cfg_beats;
                    words_form <= cfg_words;
                    words_hand <= cfg_words;
                    dma_r_len  <= len_of(cfg_beats);
                    tail_owed  <= (start[OFFSET_W-1:0] != '0) && (cfg_words == cfg_beats);
                    last_mask  <= cfg_mask;
                    primed     <= 1'b0;
                    full       <= 1'b0;
                    state      <= FETCH;
                end
                FETCH, TAIL: begin
                    if (word_take) begin
                        words_hand <= words_hand - CNT_W'(1);
                        full       <= 1'b0;
                    end
                    if (beat_fire) begin
                        dma_r_addr <= dma_r_addr + ADDR_W'(B);
                        beats_rem  <= beats_rem - CNT_W'(1);
                        dma_r_len  <= len_of(beats_rem - CNT_W'(1));
                        prev       <= dma_r_rdata;
                        primed     <= 1'b1;
                        if (offset == '0 || primed) begin
                            dbus_rdata <= finish_word(beat_word, words_form == CNT_W'(1), last_mask);
                            full       <= 1'b1;
                            words_form <= words_form - CNT_W'(1);
                        end
                    end else if (state == FETCH && beats_rem == '0 && tail_owed && (!full || word_take)) begin
                        dbus_rdata <= finish_word(tail_word, words_form == CNT_W'(1), last_mask);
                        full       <= 1'b1;
                        words_form <= words_form - CNT_W'(1);
                        tail_owed  <= 1'b0;
                        state      <= TAIL;
                    end
                    if (word_take && words_hand == CNT_W'(1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rdata_aligner.md
RDATA_ALIGNER -- requirements
Module: rdata_aligner

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width (power-of-two bytes); B=DATA_W/8, OFFSET_W=log2(B).
REQ-003 SHALL have clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have clear  input  1  synchronous abort to IDLE.
REQ-006 SHALL have run  input  1  enables acceptance of a new dbus read sequence.
REQ-007 SHALL have endAddr  input  ADDR_W  inclusive last byte address of the region.
REQ-008 SHALL have dbus_valid  input  1; dbus_addr  input  ADDR_W; dbus_rdata  output  DATA_W; dbus_ready  output  1: sequential word-read port.
REQ-009 SHALL have dma_r_valid  output  1; dma_r_addr  output  ADDR_W (B-aligned); dma_r_rdata  input  DATA_W; dma_r_ready  input  1; dma_r_len  output  `AXI_LEN_W (from axi_dma.vh).

Function
REQ-010 SHALL implement states IDLE, CONFIG, FETCH, TAIL.
REQ-011 IDLE: on run && dbus_valid, SHALL latch dbus_addr as start and go to CONFIG; later dbus_addr values are ignored (sequential by contract).
REQ-012 CONFIG (1 cycle): SHALL set offset=start[OFFSET_W-1:0], beat address=aligned(start), beats=(aligned(endAddr)-aligned(start))/B+1, words=ceil((endAddr-start+1)/B); then FETCH.
REQ-013 dma_r_len SHALL equal min(beats_remaining-1, 2^AXI_LEN_W-1), updated after every accepted beat.
REQ-014 FETCH: dma_r_valid SHALL be high while beats_remaining>0 and the output holding register is empty or consumed this cycle; a beat is accepted when dma_r_valid && dma_r_ready; then dma_r_addr += B, beats_remaining -= 1.
REQ-015 Accepted beats SHALL shift through cur/prev registers; output word = low DATA_W bits of {cur,prev} >> 8*offset (little-endian byte stream).
REQ-016 offset==0: each accepted beat SHALL yield one word; offset!=0: the first beat only primes prev, each later beat yields one word.
REQ-017 A word SHALL be presented the cycle after its beat is accepted; dbus_ready SHALL be high for exactly one cycle per word, only when dbus_valid is high; while dbus_valid is low the word is held and fetching stalls.
REQ-018 If beats are exhausted with one word still owed, SHALL enter TAIL and form that word with cur treated as zero, then finish.
REQ-019 After the last word is handed over, SHALL return to IDLE the next cycle; dma_r_valid low in IDLE, CONFIG, TAIL.
REQ-020 clear SHALL force IDLE next cycle and empty all counters/registers, dominating every other event; a beat or word handshaked in the same cycle is discarded.
REQ-021 start>endAddr SHALL be treated as a single-word region (words=1, beats=1).

Reset
REQ-022 On rst SHALL enter IDLE; dbus_ready=0, dbus_rdata=0, dma_r_valid=0, dma_r_addr=0, dma_r_len=0, all internal registers 0.
REQ-023 Reset mid-burst SHALL abandon the burst with no further handshakes.

Configuration
REQ-024 With RDATA_BYTE_MASK_EN defined, bytes of the final word beyond endAddr SHALL read 0; without it, they SHALL carry the shifted fetched data (TAIL still zero-fills).

Verification (DATA_W=32; beat@0x100=0x33221100, @0x104=0x77665544, @0x108=0xBBAA9988)
REQ-025 start 0x100, end 0x10B -> beats 0x100/0x104/0x108, dma_r_len 2,1,0; words 0x33221100, 0x77665544, 0xBBAA9988.
REQ-026 start 0x101, end 0x108 -> 3 beats, 2 words: 0x44332211, 0x88776655.
REQ-027 start 0x103, end 0x104 -> 2 beats, 1 word: 0x00004433 with RDATA_BYTE_MASK_EN, 0x66554433 without.
REQ-028 start 0x102, end 0x103 -> 1 beat, TAIL word 0x00003322.
REQ-029 1200-byte aligned region -> dma_r_len 255 until 256 beats remain, then counts 255..0; dbus_valid held low 5 cycles mid-stream stalls dma_r_valid with no word lost.
REQ-030 clear asserted at beat 3 of 10 -> IDLE next cycle, dma_r_valid=0; new sequence starting 0x200 then completes correctly.
